// File: rtl/vga_vram_arbiter.sv
// Video RAM arbiter: prefetches line N+1 into a double-buffered line buffer, giving the CPU leftover and burst-bounded slots.
// Optional VGA_ARB_UNDERRUN_EN adds a sticky overrun flag and a saturating overrun counter.
`ifndef POSITION_WIDTH
`define POSITION_WIDTH 11
`endif

module vga_vram_arbiter #(
   parameter logic [`POSITION_WIDTH-1:0] WIDTH   = `POSITION_WIDTH'd1280,
   parameter logic [`POSITION_WIDTH-1:0] HEIGHT  = `POSITION_WIDTH'd800,
   parameter logic [`POSITION_WIDTH-1:0] V_TOTAL = `POSITION_WIDTH'd831,
   parameter int PIXELS_PER_WORD = 2,
   parameter int ADDR_WIDTH      = 20,
   parameter int DATA_WIDTH      = 16,
   parameter int FETCH_BURST     = 8
) (
   input  logic                       pixel_clock,
   input  logic                       reset_n,
   input  logic [`POSITION_WIDTH-1:0] h_position,
   input  logic [`POSITION_WIDTH-1:0] v_position,
   input  logic                       cpu_req,
   input  logic                       cpu_we,
   input  logic [ADDR_WIDTH-1:0]      cpu_addr,
   input  logic [DATA_WIDTH-1:0]      cpu_wdata,
   output logic                       cpu_ack,
   output logic [DATA_WIDTH-1:0]      cpu_rdata,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic                       mem_we,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       line_wr_en,
   output logic                       line_wr_bank,
   output logic [`POSITION_WIDTH-1:0] line_wr_addr,
   output logic [DATA_WIDTH-1:0]      line_wr_data,
   output logic                       fetch_busy
`ifdef VGA_ARB_UNDERRUN_EN
   ,
   output logic                       fetch_underrun,
   output logic [7:0]                 underrun_count
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_CPU   = 2'd2;

   localparam logic [`POSITION_WIDTH-1:0] WPL = `POSITION_WIDTH'(WIDTH / PIXELS_PER_WORD);
   localparam int BW = $clog2(FETCH_BURST + 1);
   localparam logic [BW-1:0] BURST_MAX = BW'(FETCH_BURST);

   logic [1:0]                 r_state;
   logic [`POSITION_WIDTH-1:0] r_h_prev;
   logic [`POSITION_WIDTH-1:0] r_word_idx;
   logic [ADDR_WIDTH-1:0]      r_line_base;
   logic                       r_bank;
   logic                       r_fetch_busy;
   logic                       r_cpu_ack;
   logic                       r_line_wr_en;
   logic                       r_line_wr_bank;
   logic [`POSITION_WIDTH-1:0] r_line_wr_addr;
   logic [BW-1:0]              r_burst_cnt;

   logic                       w_trigger;
   logic [`POSITION_WIDTH-1:0] w_next_line;
   logic                       w_start;
   logic                       w_cpu_pending;
   logic                       w_last;
   logic [BW-1:0]              w_burst_inc;

   assign w_trigger     = (h_position == '0) && (r_h_prev != '0);
   assign w_next_line   = (v_position == V_TOTAL - 1'b1) ? '0 : v_position + 1'b1;
   assign w_start       = w_trigger && (w_next_line < HEIGHT);
   assign w_cpu_pending = cpu_req && !r_cpu_ack;
   assign w_last        = (r_word_idx == WPL - 1'b1);
   // Saturates so a request arriving late in a long fetch waits at most one more slot.
   assign w_burst_inc   = (r_burst_cnt == BURST_MAX) ? r_burst_cnt : r_burst_cnt + 1'b1;

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_h_prev       <= '0;
         r_word_idx     <= '0;
         r_line_base    <= '0;
         r_bank         <= 1'b0;
         r_fetch_busy   <= 1'b0;
         r_cpu_ack      <= 1'b0;
         r_line_wr_en   <= 1'b0;
         r_line_wr_bank <= 1'b0;
         r_line_wr_addr <= '0;
         r_burst_cnt    <= '0;
      end else begin
         r_h_prev     <= h_position;
         r_cpu_ack    <= (r_state == S_CPU);
         r_line_wr_en <= (r_state == S_FETCH);
         if (r_state == S_FETCH) begin
            r_line_wr_addr <= r_word_idx;
            r_line_wr_bank <= r_bank;
         end
         if (w_start) begin
            r_line_base  <= (w_next_line == '0) ? '0 : r_line_base + ADDR_WIDTH'(WPL);
            r_bank       <= w_next_line[0];
            r_word_idx   <= '0;
            r_burst_cnt  <= '0;
            r_fetch_busy <= 1'b1;
            r_state      <= S_FETCH;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_cpu_pending) begin
                     r_state     <= S_CPU;
                     r_burst_cnt <= '0;
                  end
               end
               S_FETCH: begin
                  if (w_last) begin
                     r_state      <= S_IDLE;
                     r_fetch_busy <= 1'b0;
                  end else begin
                     r_word_idx <= r_word_idx + 1'b1;
                     if (w_cpu_pending && (w_burst_inc == BURST_MAX)) begin
                        r_state     <= S_CPU;
                        r_burst_cnt <= '0;
                     end else begin
                        r_burst_cnt <= w_burst_inc;
                     end
                  end
               end
               S_CPU:   r_state <= r_fetch_busy ? S_FETCH : S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      if (r_state == S_FETCH) begin
         mem_addr = r_line_base + ADDR_WIDTH'(r_word_idx);
      end else if (r_state == S_CPU) begin
         mem_addr  = cpu_addr;
         mem_we    = cpu_we;
         mem_wdata = cpu_we ? cpu_wdata : '0;
      end
   end

   assign cpu_ack      = r_cpu_ack;
   assign cpu_rdata    = r_cpu_ack ? mem_rdata : '0;
   assign line_wr_en   = r_line_wr_en;
   assign line_wr_bank = r_line_wr_bank;
   assign line_wr_addr = r_line_wr_addr;
   assign line_wr_data = r_line_wr_en ? mem_rdata : '0;
   assign fetch_busy   = r_fetch_busy;

`ifdef VGA_ARB_UNDERRUN_EN
   logic       r_fetch_underrun;
   logic [7:0] r_underrun_count;
   logic       w_overrun;

   assign w_overrun = w_start && r_fetch_busy;

   always_ff @(posedge pixel_clock or negedge reset_n) begin
      if (!reset_n) begin
         r_fetch_underrun <= 1'b0;
         r_underrun_count <= '0;
      end else if (w_overrun) begin
         r_fetch_underrun <= 1'b1;
         if (r_underrun_count != 8'hFF) r_underrun_count <= r_underrun_count + 1'b1;
      end
   end

   assign fetch_underrun = r_fetch_underrun;
   assign underrun_count = r_underrun_count;
`else
   // Restarts still happen; they are simply not recorded.
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Directed bench for vga_vram_arbiter on a 16x4 (6 total lines) geometry, 2 pixels/word, burst of 2.
module tb_vga_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] h_pos;
   logic [10:0] v_pos;
   logic        cpu_req;
   logic        cpu_we;
   logic [19:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic [19:0] mem_addr;
   logic        mem_we;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        line_wr_en;
   logic        line_wr_bank;
   logic [10:0] line_wr_addr;
   logic [15:0] line_wr_data;
   logic        fetch_busy;
`ifdef VGA_ARB_UNDERRUN_EN
   logic        fetch_underrun;
   logic [7:0]  underrun_count;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   logic [15:0] ram [0:1023];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:0]];
   end

   vga_vram_arbiter #(
      .WIDTH(11'd16), .HEIGHT(11'd4), .V_TOTAL(11'd6),
      .PIXELS_PER_WORD(2), .ADDR_WIDTH(20), .DATA_WIDTH(16), .FETCH_BURST(2)
   ) dut (
      .pixel_clock(clk), .reset_n(reset_n),
      .h_position(h_pos), .v_position(v_pos),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .line_wr_en(line_wr_en), .line_wr_bank(line_wr_bank),
      .line_wr_addr(line_wr_addr), .line_wr_data(line_wr_data),
      .fetch_busy(fetch_busy)
`ifdef VGA_ARB_UNDERRUN_EN
      , .fetch_underrun(fetch_underrun), .underrun_count(underrun_count)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic trigger(input int v);
      h_pos = 11'd0;
      v_pos = 11'(v);
      step();
      h_pos = 11'd5;
   endtask

   // Called on the first FETCH cycle; walks 8 issues plus the trailing write-back.
   task automatic fetch_check(input int base, input int bank, input string nm);
      $display("fetch %s base=%0d bank=%0d", nm, base, bank);
      for (int k = 0; k < 9; k++) begin
         if (k < 8) begin
            check_eq({nm, "_addr"}, 32'(mem_addr), 32'(base + k));
            check_eq({nm, "_busy"}, 32'(fetch_busy), 32'd1);
            check_eq({nm, "_we"}, 32'(mem_we), 32'd0);
         end else begin
            check_eq({nm, "_busy_end"}, 32'(fetch_busy), 32'd0);
         end
         check_eq({nm, "_wr_en"}, 32'(line_wr_en), (k > 0) ? 32'd1 : 32'd0);
         if (k > 0) begin
            check_eq({nm, "_wr_addr"}, 32'(line_wr_addr), 32'(k - 1));
            check_eq({nm, "_wr_bank"}, 32'(line_wr_bank), 32'(bank));
            check_eq({nm, "_wr_data"}, 32'(line_wr_data), 32'(16'hA000 + base + k - 1));
         end
         step();
      end
      check_eq({nm, "_wr_idle"}, 32'(line_wr_en), 32'd0);
   endtask

   task automatic no_fetch_check(input string nm);
      $display("no-fetch %s", nm);
      for (int k = 0; k < 3; k++) begin
         check_eq({nm, "_busy"}, 32'(fetch_busy), 32'd0);
         check_eq({nm, "_addr"}, 32'(mem_addr), 32'd0);
         check_eq({nm, "_wr_en"}, 32'(line_wr_en), 32'd0);
         step();
      end
   endtask

   initial begin
      string slots;
      int    widx;
      for (int i = 0; i < 1024; i++) ram[i] = 16'(16'hA000 + i);
      ram[10'h123] = 16'hBEEF;
      reset_n = 1'b0; h_pos = 11'd5; v_pos = 11'd0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      step(); step();
      $display("reset state");
      check_eq("rst_busy", 32'(fetch_busy), 32'd0);
      check_eq("rst_ack", 32'(cpu_ack), 32'd0);
      check_eq("rst_addr", 32'(mem_addr), 32'd0);
      check_eq("rst_we", 32'(mem_we), 32'd0);
      check_eq("rst_wr_en", 32'(line_wr_en), 32'd0);
`ifdef VGA_ARB_UNDERRUN_EN
      check_eq("rst_underrun", 32'(fetch_underrun), 32'd0);
      check_eq("rst_ucount", 32'(underrun_count), 32'd0);
`endif
      reset_n = 1'b1;
      step(); step(); step();

      // Idle fetch of line 1 into bank 1
      trigger(0);
      fetch_check(8, 1, "idle");
      step();

      trigger(3);
      no_fetch_check("blank3");
      trigger(4);
      no_fetch_check("blank4");
      trigger(5);
      fetch_check(0, 0, "wrap");
      step();

      // Interleaved CPU writes; request raised together with the trigger
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h200; cpu_wdata = 16'h5A5A;
      trigger(0);
      $display("interleave write");
      slots = "FFCFFCFFFF";
      widx = 0;
      for (int c = 1; c <= 11; c++) begin
         if (c <= 10) begin
            check_eq("il_busy", 32'(fetch_busy), 32'd1);
            if (slots[c-1] == "F") begin
               check_eq("il_f_addr", 32'(mem_addr), 32'(8 + widx));
               check_eq("il_f_we", 32'(mem_we), 32'd0);
               widx++;
            end else begin
               check_eq("il_c_addr", 32'(mem_addr), 32'h200);
               check_eq("il_c_we", 32'(mem_we), 32'd1);
               check_eq("il_c_wdata", 32'(mem_wdata), 32'(cpu_wdata));
            end
         end else begin
            check_eq("il_busy_end", 32'(fetch_busy), 32'd0);
         end
         check_eq("il_wr_en", 32'(line_wr_en), (c > 1 && slots[c-2] == "F") ? 32'd1 : 32'd0);
         check_eq("il_ack", 32'(cpu_ack), (c > 1 && slots[c-2] == "C") ? 32'd1 : 32'd0);
         if (c == 4) cpu_wdata = 16'h3C3C;
         if (c == 7) cpu_req = 1'b0;
         step();
      end
      check_eq("il_ram", 32'(ram[10'h200]), 32'h3C3C);
      check_eq("il_words", 32'(widx), 32'd8);
      step();

      // CPU read while idle
      $display("cpu read 0x123");
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h123;
      step();
      check_eq("rd_addr", 32'(mem_addr), 32'h123);
      check_eq("rd_we", 32'(mem_we), 32'd0);
      check_eq("rd_ack_early", 32'(cpu_ack), 32'd0);
      step();
      check_eq("rd_ack", 32'(cpu_ack), 32'd1);
      check_eq("rd_data", 32'(cpu_rdata), 32'hBEEF);
      cpu_req = 1'b0;
      step();
      check_eq("rd_ack_done", 32'(cpu_ack), 32'd0);
      check_eq("rd_addr_idle", 32'(mem_addr), 32'd0);
      step();

      // Asynchronous reset while issuing word 3 of line 2
      $display("reset mid-fetch");
      trigger(1);
      step(); step(); step();
      check_eq("mr_addr_w3", 32'(mem_addr), 32'd19);
      reset_n = 1'b0;
      #1;
      check_eq("mr_addr", 32'(mem_addr), 32'd0);
      check_eq("mr_busy", 32'(fetch_busy), 32'd0);
      check_eq("mr_wr_en", 32'(line_wr_en), 32'd0);
      check_eq("mr_wr_data", 32'(line_wr_data), 32'd0);
      check_eq("mr_wr_addr", 32'(line_wr_addr), 32'd0);
      check_eq("mr_ack", 32'(cpu_ack), 32'd0);
      step(); step();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check_eq("mr_quiet", 32'(line_wr_en), 32'd0);
         step();
      end
      trigger(0);
      fetch_check(8, 1, "post_rst");
      step();

      // Overrun: new trigger while issuing word 5 of line 2
      $display("overrun restart");
      trigger(1);
      for (int k = 0; k < 5; k++) step();
      check_eq("ov_addr_w5", 32'(mem_addr), 32'd21);
      trigger(2);
      check_eq("ov_restart_addr", 32'(mem_addr), 32'd24);
      check_eq("ov_old_wr_addr", 32'(line_wr_addr), 32'd5);
      check_eq("ov_old_wr_bank", 32'(line_wr_bank), 32'd0);
      step();
      check_eq("ov_new_wr_addr", 32'(line_wr_addr), 32'd0);
      check_eq("ov_new_wr_bank", 32'(line_wr_bank), 32'd1);
      check_eq("ov_new_wr_data", 32'(line_wr_data), 32'hA018);
      for (int k = 1; k < 8; k++) begin
         check_eq("ov_addr", 32'(mem_addr), 32'(24 + k));
         check_eq("ov_busy", 32'(fetch_busy), 32'd1);
         step();
      end
      check_eq("ov_busy_end", 32'(fetch_busy), 32'd0);
`ifdef VGA_ARB_UNDERRUN_EN
      check_eq("ov_underrun", 32'(fetch_underrun), 32'd1);
      check_eq("ov_ucount", 32'(underrun_count), 32'd1);
`endif
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
